// File: rtl/cpu_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, owner encoding and
// the default memory latency.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } mem_arb_state_t;

  typedef enum logic {
    OWN_DATA   = 1'b0,
    OWN_IFETCH = 1'b1
  } mem_owner_t;

  localparam int MEM_LATENCY_DEFAULT = 1;
  // Latency counter holds MEM_LATENCY-1, and MEM_LATENCY is at most 15.
  localparam int CNT_W = 4;
  // Bit positions of the data and fetch requesters in req/gnt vectors.
  localparam int GNT_D = 0;
  localparam int GNT_I = 1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the core-side fetch/data ports and the memory-side command port.
// slave = arbiter view, master = core + memory view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter. Grant is combinational while enabled;
// the priority flips to the other requester after every grant.
module rr_arb2
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  mem_owner_t prio_q, prio_d;

  always_comb begin
    gnt    = '0;
    prio_d = prio_q;
    if (en) begin
      if (req[GNT_D] && (!req[GNT_I] || prio_q == OWN_DATA)) begin
        gnt[GNT_D] = 1'b1;
        prio_d     = OWN_IFETCH;
      end else if (req[GNT_I]) begin
        gnt[GNT_I] = 1'b1;
        prio_d     = OWN_DATA;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prio_q <= OWN_DATA;
    else       prio_q <= prio_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data load/store,
// one transaction in flight, round-robin under contention.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int MEM_LATENCY = MEM_LATENCY_DEFAULT,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  mem_arb_state_t    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  mem_owner_t        owner_q, owner_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [1:0]        req, gnt;
  logic              arb_en;

  assign req[GNT_D] = bus.d_req;
  assign req[GNT_I] = bus.if_req;
  // Gating with reset keeps gnt low while reset is held, even with req high.
  assign arb_en     = (state_q == IDLE) && !reset;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (arb_en),
    .req   (req),
    .gnt   (gnt)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    owner_d     = owner_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (gnt[GNT_I]) begin
          addr_d  = bus.if_addr;
          we_d    = 1'b0;
          owner_d = OWN_IFETCH;
          state_d = ISSUE;
        end else if (gnt[GNT_D]) begin
          addr_d  = bus.d_addr;
          wdata_d = bus.d_wdata;
          we_d    = bus.d_we;
          owner_d = OWN_DATA;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(MEM_LATENCY - 1);
        state_d = (MEM_LATENCY == 1) ? RESP : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_d == '0) state_d = RESP;
      end
      RESP: begin
        if (owner_q == OWN_IFETCH) begin
          if_rvalid_d = 1'b1;
          if_rdata_d  = bus.mem_rdata;
        end else begin
          d_rvalid_d = 1'b1;
          d_rdata_d  = we_q ? '0 : bus.mem_rdata;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      owner_q     <= OWN_DATA;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      owner_q     <= owner_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Commands decode from the state flop, so an async reset drops them at once.
  assign bus.mem_read  = (state_q == ISSUE) && !we_q;
  assign bus.mem_write = (state_q == ISSUE) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_gnt    = gnt[GNT_I];
  assign bus.d_gnt     = gnt[GNT_D];
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance A with MEM_LATENCY=1, instance B with
// MEM_LATENCY=3, each backed by a small latency-accurate memory model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset_a, reset_b;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ba ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bb ();

  mem_arbiter #(.MEM_LATENCY(1), .ADDR_W(32), .DATA_W(32)) u_dut_a (
    .clk(clk), .reset(reset_a), .bus(ba));
  mem_arbiter #(.MEM_LATENCY(3), .ADDR_W(32), .DATA_W(32)) u_dut_b (
    .clk(clk), .reset(reset_b), .bus(bb));

  // Memory models: read data appears MEM_LATENCY cycles after mem_read,
  // junk otherwise so a mistimed sample is visible.
  logic [31:0] mem_a [0:255];
  logic [31:0] mem_b [0:255];
  logic [31:0] pipe_a;
  logic [31:0] pipe_b [0:2];

  always @(posedge clk) begin
    pipe_a <= ba.mem_read ? mem_a[ba.mem_addr[9:2]] : 32'hBAD0_BAD0;
    if (ba.mem_write) mem_a[ba.mem_addr[9:2]] <= ba.mem_wdata;
    pipe_b[0] <= bb.mem_read ? mem_b[bb.mem_addr[9:2]] : 32'hBAD0_BAD0;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
    if (bb.mem_write) mem_b[bb.mem_addr[9:2]] <= bb.mem_wdata;
  end
  assign ba.mem_rdata = pipe_a;
  assign bb.mem_rdata = pipe_b[2];

  task automatic clear_inputs();
    ba.if_req = 1'b0; ba.if_addr = '0; ba.d_req = 1'b0; ba.d_we = 1'b0;
    ba.d_addr = '0; ba.d_wdata = '0;
    bb.if_req = 1'b0; bb.if_addr = '0; bb.d_req = 1'b0; bb.d_we = 1'b0;
    bb.d_addr = '0; bb.d_wdata = '0;
  endtask

  // Leaves the caller at the drive point of the first cycle with reset low.
  task automatic pulse_reset_a();
    reset_a = 1'b1;
    @(posedge clk); #1;
    reset_a = 1'b0;
  endtask

  task automatic pulse_reset_b();
    reset_b = 1'b1;
    @(posedge clk); #1;
    reset_b = 1'b0;
  endtask

  task automatic test_reset();
    reset_a = 1'b1; reset_b = 1'b1;
    ba.if_req = 1'b1; ba.d_req = 1'b1; bb.if_req = 1'b1; bb.d_req = 1'b1;
    @(negedge clk);
    if ({ba.if_gnt, ba.d_gnt, ba.if_rvalid, ba.d_rvalid, ba.mem_read, ba.mem_write} !== 6'b0) begin
      n_fail++; $display("FAIL reset_a_ctrl: got %b expected 000000",
        {ba.if_gnt, ba.d_gnt, ba.if_rvalid, ba.d_rvalid, ba.mem_read, ba.mem_write});
    end
    n_tests++;
    if ({ba.if_rdata, ba.d_rdata, ba.mem_addr, ba.mem_wdata} !== 128'b0) begin
      n_fail++; $display("FAIL reset_a_data: got %h expected 0",
        {ba.if_rdata, ba.d_rdata, ba.mem_addr, ba.mem_wdata});
    end
    n_tests++;
    if ({bb.if_gnt, bb.d_gnt, bb.if_rvalid, bb.d_rvalid, bb.mem_read, bb.mem_write} !== 6'b0) begin
      n_fail++; $display("FAIL reset_b_ctrl: got %b expected 000000",
        {bb.if_gnt, bb.d_gnt, bb.if_rvalid, bb.d_rvalid, bb.mem_read, bb.mem_write});
    end
    n_tests++;
    clear_inputs();
    @(posedge clk); #1;
    reset_a = 1'b0; reset_b = 1'b0;
    $display("[TB] reset: outputs checked with requests held high");
  endtask

  task automatic test_fetch_single();
    logic e;
    for (int c = 0; c < 6; c++) begin
      if (c == 0) begin ba.if_req = 1'b1; ba.if_addr = 32'h10; end
      if (c == 1) ba.if_req = 1'b0;
      @(negedge clk);
      e = (c == 0);
      if (ba.if_gnt !== e) begin n_fail++; $display("FAIL fetch_gnt c=%0d: got %b expected %b", c, ba.if_gnt, e); end
      n_tests++;
      e = (c == 1);
      if (ba.mem_read !== e) begin n_fail++; $display("FAIL fetch_mem_read c=%0d: got %b expected %b", c, ba.mem_read, e); end
      n_tests++;
      if (c == 1 && ba.mem_addr !== 32'h10) begin n_fail++; $display("FAIL fetch_mem_addr: got %h expected 00000010", ba.mem_addr); end
      e = (c == 3);
      if (ba.if_rvalid !== e) begin n_fail++; $display("FAIL fetch_rvalid c=%0d: got %b expected %b", c, ba.if_rvalid, e); end
      n_tests++;
      if (c == 3 && ba.if_rdata !== 32'h0050_0093) begin n_fail++; $display("FAIL fetch_rdata: got %h expected 00500093", ba.if_rdata); end
      if (ba.d_rvalid !== 1'b0) begin n_fail++; $display("FAIL fetch_d_rvalid c=%0d: got %b expected 0", c, ba.d_rvalid); end
      n_tests++;
      if (c == 3) $display("[TB] fetch 0x10 -> %h", ba.if_rdata);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_contention();
    logic e;
    pulse_reset_a();
    for (int c = 0; c < 8; c++) begin
      if (c == 0) begin
        ba.d_req = 1'b1; ba.d_we = 1'b0; ba.d_addr = 32'h40;
        ba.if_req = 1'b1; ba.if_addr = 32'h14;
      end
      if (c == 1) ba.d_req = 1'b0;
      if (c == 4) ba.if_req = 1'b0;
      @(negedge clk);
      e = (c == 0);
      if (ba.d_gnt !== e) begin n_fail++; $display("FAIL cont_d_gnt c=%0d: got %b expected %b", c, ba.d_gnt, e); end
      n_tests++;
      e = (c == 3);
      if (ba.if_gnt !== e) begin n_fail++; $display("FAIL cont_if_gnt c=%0d: got %b expected %b", c, ba.if_gnt, e); end
      n_tests++;
      e = (c == 1 || c == 4);
      if (ba.mem_read !== e) begin n_fail++; $display("FAIL cont_mem_read c=%0d: got %b expected %b", c, ba.mem_read, e); end
      n_tests++;
      if (c == 1 && ba.mem_addr !== 32'h40) begin n_fail++; $display("FAIL cont_addr_d: got %h expected 00000040", ba.mem_addr); end
      if (c == 4 && ba.mem_addr !== 32'h14) begin n_fail++; $display("FAIL cont_addr_i: got %h expected 00000014", ba.mem_addr); end
      e = (c == 3);
      if (ba.d_rvalid !== e) begin n_fail++; $display("FAIL cont_d_rvalid c=%0d: got %b expected %b", c, ba.d_rvalid, e); end
      n_tests++;
      if (c == 3 && ba.d_rdata !== 32'h1111_2222) begin n_fail++; $display("FAIL cont_d_rdata: got %h expected 11112222", ba.d_rdata); end
      e = (c == 6);
      if (ba.if_rvalid !== e) begin n_fail++; $display("FAIL cont_if_rvalid c=%0d: got %b expected %b", c, ba.if_rvalid, e); end
      n_tests++;
      if (c == 6 && ba.if_rdata !== 32'h3333_4444) begin n_fail++; $display("FAIL cont_if_rdata: got %h expected 33334444", ba.if_rdata); end
      if (c == 6) $display("[TB] contention: load 0x40 -> %h, fetch 0x14 -> %h", ba.d_rdata, ba.if_rdata);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic ed, ei, erd, eri;
    pulse_reset_a();
    ba.d_req = 1'b1; ba.d_we = 1'b0; ba.d_addr = 32'h40;
    ba.if_req = 1'b1; ba.if_addr = 32'h14;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      ed  = (c % 3 == 0) && ((c / 3) % 2 == 0);
      ei  = (c % 3 == 0) && ((c / 3) % 2 == 1);
      erd = (c > 0) && (c % 3 == 0) && ((c / 3) % 2 == 1);
      eri = (c > 0) && (c % 3 == 0) && ((c / 3) % 2 == 0);
      if ({ba.d_gnt, ba.if_gnt} !== {ed, ei}) begin
        n_fail++; $display("FAIL b2b_gnt c=%0d: got d/i=%b%b expected %b%b", c, ba.d_gnt, ba.if_gnt, ed, ei);
      end
      n_tests++;
      if ({ba.d_rvalid, ba.if_rvalid} !== {erd, eri}) begin
        n_fail++; $display("FAIL b2b_rvalid c=%0d: got d/i=%b%b expected %b%b", c, ba.d_rvalid, ba.if_rvalid, erd, eri);
      end
      n_tests++;
      if (ba.mem_read && ba.mem_write) begin
        n_fail++; $display("FAIL b2b_overlap c=%0d: got read=1 write=1 expected at most one", c);
      end
      n_tests++;
      if (ed || ei) $display("[TB] b2b grant c=%0d -> %s", c, ed ? "D" : "I");
      @(posedge clk); #1;
    end
    clear_inputs();
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic test_store_load();
    logic e;
    for (int c = 0; c < 8; c++) begin
      if (c == 0) begin ba.d_req = 1'b1; ba.d_we = 1'b1; ba.d_addr = 32'h40; ba.d_wdata = 32'hDEAD_BEEF; end
      if (c == 1) ba.d_req = 1'b0;
      if (c == 3) begin ba.d_req = 1'b1; ba.d_we = 1'b0; ba.d_wdata = '0; end
      if (c == 4) ba.d_req = 1'b0;
      @(negedge clk);
      e = (c == 1);
      if (ba.mem_write !== e) begin n_fail++; $display("FAIL st_mem_write c=%0d: got %b expected %b", c, ba.mem_write, e); end
      n_tests++;
      e = (c == 4);
      if (ba.mem_read !== e) begin n_fail++; $display("FAIL st_mem_read c=%0d: got %b expected %b", c, ba.mem_read, e); end
      n_tests++;
      if (c == 1 && {ba.mem_addr, ba.mem_wdata} !== {32'h40, 32'hDEAD_BEEF}) begin
        n_fail++; $display("FAIL st_cmd: got addr=%h wdata=%h expected 00000040 deadbeef", ba.mem_addr, ba.mem_wdata);
      end
      e = (c == 0 || c == 3);
      if (ba.d_gnt !== e) begin n_fail++; $display("FAIL st_d_gnt c=%0d: got %b expected %b", c, ba.d_gnt, e); end
      n_tests++;
      e = (c == 3 || c == 6);
      if (ba.d_rvalid !== e) begin n_fail++; $display("FAIL st_d_rvalid c=%0d: got %b expected %b", c, ba.d_rvalid, e); end
      n_tests++;
      if (c == 3 && ba.d_rdata !== 32'h0) begin n_fail++; $display("FAIL st_store_rdata: got %h expected 00000000", ba.d_rdata); end
      if (c == 6 && ba.d_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL st_load_rdata: got %h expected deadbeef", ba.d_rdata); end
      if (c == 3) $display("[TB] store 0x40 <- deadbeef complete");
      if (c == 6) $display("[TB] load 0x40 -> %h", ba.d_rdata);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_latency3();
    logic e;
    pulse_reset_b();
    for (int c = 0; c < 7; c++) begin
      if (c == 0) begin bb.if_req = 1'b1; bb.if_addr = 32'h20; end
      if (c == 1) bb.if_req = 1'b0;
      @(negedge clk);
      e = (c == 0);
      if (bb.if_gnt !== e) begin n_fail++; $display("FAIL l3_gnt c=%0d: got %b expected %b", c, bb.if_gnt, e); end
      n_tests++;
      e = (c == 1);
      if (bb.mem_read !== e) begin n_fail++; $display("FAIL l3_mem_read c=%0d: got %b expected %b", c, bb.mem_read, e); end
      n_tests++;
      e = (c == 5);
      if (bb.if_rvalid !== e) begin n_fail++; $display("FAIL l3_rvalid c=%0d: got %b expected %b", c, bb.if_rvalid, e); end
      n_tests++;
      if (c >= 5 && bb.if_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL l3_rdata c=%0d: got %h expected cafef00d", c, bb.if_rdata); end
      if (c == 5) $display("[TB] L3 fetch 0x20 -> %h", bb.if_rdata);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midflight();
    logic e;
    pulse_reset_b();
    for (int c = 0; c < 10; c++) begin
      if (c == 0) begin bb.if_req = 1'b1; bb.if_addr = 32'h24; end
      if (c == 1) bb.if_req = 1'b0;
      if (c == 2) begin reset_b = 1'b1; bb.if_req = 1'b1; bb.if_addr = 32'h28; end
      if (c == 3) reset_b = 1'b0;
      if (c == 4) bb.if_req = 1'b0;
      @(negedge clk);
      if (c == 2 && {bb.if_gnt, bb.if_rvalid, bb.mem_read, bb.mem_write, bb.mem_addr, bb.if_rdata} !== 68'b0) begin
        n_fail++; $display("FAIL mid_reset_outputs: got gnt=%b rv=%b rd=%b wr=%b addr=%h rdata=%h expected all 0",
          bb.if_gnt, bb.if_rvalid, bb.mem_read, bb.mem_write, bb.mem_addr, bb.if_rdata);
      end
      e = (c == 0 || c == 3);
      if (bb.if_gnt !== e) begin n_fail++; $display("FAIL mid_gnt c=%0d: got %b expected %b", c, bb.if_gnt, e); end
      n_tests++;
      e = (c == 1 || c == 4);
      if (bb.mem_read !== e) begin n_fail++; $display("FAIL mid_mem_read c=%0d: got %b expected %b", c, bb.mem_read, e); end
      n_tests++;
      if (c == 4 && bb.mem_addr !== 32'h28) begin n_fail++; $display("FAIL mid_addr: got %h expected 00000028", bb.mem_addr); end
      e = (c == 8);
      if (bb.if_rvalid !== e) begin n_fail++; $display("FAIL mid_rvalid c=%0d: got %b expected %b", c, bb.if_rvalid, e); end
      n_tests++;
      if (c == 8 && bb.if_rdata !== 32'h0000_ABCD) begin n_fail++; $display("FAIL mid_rdata: got %h expected 0000abcd", bb.if_rdata); end
      if (c == 8) $display("[TB] post-reset fetch 0x28 -> %h", bb.if_rdata);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin mem_a[i] = 32'h0; mem_b[i] = 32'h0; end
    mem_a[32'h10 >> 2] = 32'h0050_0093;
    mem_a[32'h14 >> 2] = 32'h3333_4444;
    mem_a[32'h40 >> 2] = 32'h1111_2222;
    mem_b[32'h20 >> 2] = 32'hCAFE_F00D;
    mem_b[32'h24 >> 2] = 32'h1234_5678;
    mem_b[32'h28 >> 2] = 32'h0000_ABCD;
    reset_a = 1'b1; reset_b = 1'b1;
    clear_inputs();
    @(posedge clk); #1;
    test_reset();
    test_fetch_single();
    test_contention();
    test_back_to_back();
    test_store_load();
    test_latency3();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
